// File: rtl/uart_tx_periph_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph_if
// Description : CPU data-bus bundle seen by the UART transmitter peripheral.
//               master : CPU side, drives address/strobes/store data and
//                        receives load data.
//               slave  : peripheral side, samples the bus and returns rdata.
//   addr     [31:0] byte address
//   MemWrite        store strobe
//   MemRead         load strobe
//   wdata    [31:0] store data
//   rdata    [31:0] load data (combinational from the peripheral)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_periph_if;
    logic [31:0] addr;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output MemWrite,
        output MemRead,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  MemWrite,
        input  MemRead,
        input  wdata,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_periph
// Description : Memory-mapped 8N1 UART transmitter.
//               0x18 UART_TXD (write-only) : store loads wdata[7:0]
//               0x20 UART_CON (read-only)  : [5] parity capability,
//                   [4] tx_busy, [2] tx_done (sticky), [1] overrun (sticky)
//               A UART_CON load clears the sticky bits in the next cycle.
//               Optional: define UART_TX_PARITY_EN to append an even-parity
//               bit after the data bits (and report bit5 = 1).
// Ports       : clk, reset (sync, active-high)
//               bus      - uart_tx_periph_if.slave data-bus bundle
//               tx       - serial output, idle high
//               tx_busy  - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
    parameter int          BAUD_DIV  = 10416,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  wire                      clk,
    input  wire                      reset,
    uart_tx_periph_if.slave          bus,
    output logic                     tx,
    output logic                     tx_busy
);

    localparam int                   c_cnt_w   = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [7:0]           c_off_txd = 8'h18;
    localparam logic [7:0]           c_off_con = 8'h20;

`ifdef UART_TX_PARITY_EN
    localparam logic c_parity_cap = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;
`else
    localparam logic c_parity_cap = 1'b0;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_done;
    logic                 r_overrun;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [2:0]           w_bit_nxt;
    logic [7:0]           w_shift_nxt;
    logic                 w_tx_nxt;
    logic                 w_done_set;
    logic                 w_page_hit;
    logic                 w_txd_wr;
    logic                 w_con_rd;
    logic                 w_busy;
    logic                 w_baud_end;
    logic [31:0]          w_rdata;
    logic                 w_unused_bits;

    assign w_page_hit = (bus.addr[31:8] == BASE_ADDR[31:8]);
    assign w_txd_wr   = bus.MemWrite && w_page_hit && (bus.addr[7:0] == c_off_txd);
    assign w_con_rd   = bus.MemRead  && w_page_hit && (bus.addr[7:0] == c_off_con);
    // Busy covers the whole frame including the last stop-bit cycle, so a
    // store landing on that cycle is still counted as an overrun.
    assign w_busy     = (r_state != ST_IDLE);
    assign w_baud_end = (r_baud_cnt == c_cnt_max);
    assign w_unused_bits = ^bus.wdata[31:8];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            // Set wins over the clearing read in the same cycle.
            r_done     <= w_done_set | (r_done & ~w_con_rd);
            r_overrun  <= (w_txd_wr & w_busy) | (r_overrun & ~w_con_rd);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured with the byte because the shift register is
    // consumed while the data bits go out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_txd_wr && !w_busy) begin
            r_parity <= ^bus.wdata[7:0];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic. tx is registered, so the value computed here for
    // a transition is what the line shows in the first cycle of the new
    // bit.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_done_set  = 1'b0;

        if (r_state != ST_IDLE) begin
            w_cnt_nxt = w_baud_end ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_txd_wr) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_shift_nxt = bus.wdata[7:0];
                    w_tx_nxt    = 1'b0;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_baud_end) begin
                    w_state_nxt = ST_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 32'd0;
        if (w_con_rd) begin
            w_rdata = {26'd0, c_parity_cap, w_busy, 1'b0, r_done, r_overrun, 1'b0};
        end
    end

    assign bus.rdata = w_rdata;
    assign tx        = r_tx;
    assign tx_busy   = w_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter that answers CPU load and store accesses in the 0x4000_00xx peripheral space.
- Software writes a byte to UART_TXD at 0x4000_0018. It polls UART_CON at 0x4000_0020 and waits for bit 4 (tx busy) to clear before issuing the next write.
- Serializes 8N1 frames onto a single TX line.
- Sits beside the timer, LED and digital-tube peripherals on the pipelined CPU's data bus.

Parameters:
- BAUD_DIV, 10416: clock cycles per serial bit (100 MHz / 9600 baud). Legal range ≥ 2.
- BASE_ADDR, 32'h4000_0000: peripheral base address.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  data bus byte address.
- MemWrite  in  1  store strobe, sampled on rising clk.
- MemRead  in  1  load strobe.
- wdata  in  32  store data.
- rdata  out  32  load data (combinational).
- tx  out  1  serial output; idle high.
- tx_busy  out  1  frame in progress; mirrors UART_CON[4].

Behaviour:
- Register map, offsets from BASE_ADDR:
  - 0x18 UART_TXD: write-only; a store loads wdata[7:0]; reads return 0.
  - 0x20 UART_CON: read-only.
    - bit4 tx_busy.
    - bit2 tx_done: sticky, set at the end of the stop bit.
    - bit1 overrun: sticky, set on a TXD write while busy.
    - All other bits read 0.
  - Any other address: rdata = 0, writes ignored.
- rdata is 0 whenever MemRead = 0.
- Reset (synchronous): state IDLE, tx = 1, tx_busy = 0, tx_done = 0, overrun = 0, baud counter = 0, bit index = 0, shift register = 0.
- State machine:
  - IDLE: tx = 1.
    - A TXD store in cycle N latches the byte, enters START and makes tx = 0 and tx_busy = 1 visible at N+1.
  - START: tx = 0 for BAUD_DIV cycles, then → DATA.
  - DATA: shift LSB first, each bit held BAUD_DIV cycles; after bit 7 → STOP (→ PARITY when the optional feature is enabled).
  - STOP: tx = 1 for BAUD_DIV cycles, then → IDLE, tx_busy = 0, tx_done = 1.
- Frame length: exactly 10·BAUD_DIV cycles from the first low cycle to tx_busy falling (11·BAUD_DIV with parity).
- Baud counter:
  - Counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary.
  - Cleared on entry to START.
  - No free-running phase, so the start-bit edge is exactly 1 cycle after the store.
- Write while busy: the byte is discarded, overrun is set, and the frame in flight is unaffected.
- Write in the same cycle the STOP bit ends: treated as busy, so the byte is discarded and overrun is set. Software must observe busy = 0 first.
- Clearing the sticky bits:
  - A UART_CON read (MemRead with addr = 0x20) clears tx_done and overrun in the following cycle.
  - The read itself returns the pre-clear values.
  - If tx_done is set in the same cycle as the clearing read, set wins.
- MemRead and MemWrite both high to different addresses: each is handled independently.
- Reset asserted mid-frame: frame aborted, tx = 1 the next cycle, all state at reset values. No partial stop bit is required.
- Only addr[7:0] is decoded within the page; addr[31:8] must equal BASE_ADDR[31:8].

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent after bit 7 for BAUD_DIV cycles, before STOP.
  - UART_CON bit5 reads 1 as a capability flag.
- Undefined:
  - Pure 8N1 frames.
  - UART_CON bit5 reads 0.
  - No parity logic synthesized.

Test Plan (BAUD_DIV = 4):
- Reset held 2 cycles, then released: tx = 1, tx_busy = 0, UART_CON read = 0x00.
- Store 0x0000_00A5 to 0x4000_0018 at cycle N:
  - tx low during N+1..N+4.
  - Bits 1,0,1,0,0,1,0,1 follow, 4 cycles each.
  - High stop bit during N+37..N+40.
  - tx_busy falls at N+41; UART_CON then reads 0x04.
- Same frame, with a UART_CON read at N+10: returns 0x10. A second store 0x3C at N+12 is dropped and UART_CON then reads 0x12. The next read returns 0x10, with the sticky bits cleared.
- Store 0x5A, then reset asserted at N+15: tx = 1 and tx_busy = 0 at N+16. A new store 0x01 afterwards produces a clean frame.
- Accesses off the map:
  - Store to 0x4000_001C: no frame.
  - Load from 0x4000_0018: returns 0.
  - Load from 0x4000_0024: returns 0.
- With UART_TX_PARITY_EN, store 0x07: parity bit 1 after the data bits, frame of 44 cycles, UART_CON bit5 = 1.
